// File: rtl/vec_mem_stage_if.sv
// Narrow data-memory beat port between the vector MEM stage (master) and memory (slave).
interface vec_mem_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEAT_W = 64
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [BEAT_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/vec_mem_stage.sv
// Vector MEM stage: splits VEC_W loads/stores into BEAT_W memory beats, stalls upstream
// while busy and registers the MEM/WB bundle.
module vec_mem_stage #(
    parameter int unsigned VEC_W  = 256,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ValidM,
    input  logic               PCSrcM,
    input  logic               RegWriteM,
    input  logic               MemWriteM,
    input  logic               MemtoRegM,
    input  logic [VEC_W-1:0]   ALUResultM,
    input  logic [VEC_W-1:0]   WriteDataM,
    input  logic [2:0]         WA3M,
    output logic               StallM,
    vec_mem_stage_if.master    mem,
    output logic               ValidW,
    output logic               PCSrcW,
    output logic               RegWriteW,
    output logic               MemtoRegW,
    output logic [VEC_W-1:0]   ALUOutW,
    output logic [VEC_W-1:0]   ReadDataW,
    output logic [2:0]         WA3W
);
    localparam int unsigned NBEATS = VEC_W / BEAT_W;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(NBEATS - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(BEAT_BYTES - ADDR_W'(1));

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_REQ  = 2'd1;
    localparam logic [1:0] RD_REQ  = 2'd2;
    localparam logic [1:0] RD_WAIT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [VEC_W-1:0]  wdata_q, wdata_d;
    logic [VEC_W-1:0]  alu_q, alu_d;
    logic [VEC_W-1:0]  rbuf_q, rbuf_d;
    logic              pcsrc_q, pcsrc_d;
    logic              regwrite_q, regwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic [2:0]        wa3_q, wa3_d;

    logic              valid_w_q, valid_w_d;
    logic              pcsrc_w_q, pcsrc_w_d;
    logic              regwrite_w_q, regwrite_w_d;
    logic              memtoreg_w_q, memtoreg_w_d;
    logic [VEC_W-1:0]  aluout_w_q, aluout_w_d;
    logic [VEC_W-1:0]  readdata_w_q, readdata_w_d;
    logic [2:0]        wa3_w_q, wa3_w_d;

    logic              last_beat;
    logic              last_done;
    logic [ADDR_W-1:0] beat_addr;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        alu_d        = alu_q;
        rbuf_d       = rbuf_q;
        pcsrc_d      = pcsrc_q;
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        wa3_d        = wa3_q;
        // W stage sees a bubble unless an instruction retires this cycle.
        valid_w_d    = 1'b0;
        pcsrc_w_d    = 1'b0;
        regwrite_w_d = 1'b0;
        memtoreg_w_d = 1'b0;
        aluout_w_d   = aluout_w_q;
        readdata_w_d = readdata_w_q;
        wa3_w_d      = wa3_w_q;
        mem.req      = 1'b0;
        mem.we       = 1'b0;
        mem.addr     = '0;
        mem.wdata    = '0;
        StallM       = 1'b0;
        last_done    = 1'b0;
        last_beat    = (beat_q == LAST_BEAT);
        beat_addr    = base_q + ADDR_W'(beat_q) * BEAT_BYTES;

        case (state_q)
            IDLE: begin
                if (ValidM && (MemWriteM || MemtoRegM)) begin
                    StallM     = 1'b1;
                    base_d     = ALUResultM[ADDR_W-1:0] & ALIGN_MASK;
                    beat_d     = '0;
                    wdata_d    = WriteDataM;
                    alu_d      = ALUResultM;
                    pcsrc_d    = PCSrcM;
                    regwrite_d = RegWriteM;
                    memtoreg_d = MemtoRegM;
                    wa3_d      = WA3M;
                    if (MemWriteM) begin
                        state_d = WR_REQ;
                    end else begin
                        rbuf_d  = '0;
                        state_d = RD_REQ;
                    end
                end else begin
                    valid_w_d    = ValidM;
                    pcsrc_w_d    = ValidM & PCSrcM;
                    regwrite_w_d = ValidM & RegWriteM;
                    memtoreg_w_d = MemtoRegM;
                    aluout_w_d   = ALUResultM;
                    readdata_w_d = '0;
                    wa3_w_d      = WA3M;
                end
            end
            WR_REQ: begin
                mem.req   = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = beat_addr;
                mem.wdata = wdata_q[beat_q*BEAT_W +: BEAT_W];
                if (mem.gnt) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        last_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            RD_REQ: begin
                mem.req  = 1'b1;
                mem.addr = beat_addr;
                if (mem.gnt) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem.rvalid) begin
                    rbuf_d[beat_q*BEAT_W +: BEAT_W] = mem.rdata;
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        last_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            StallM = !last_done;
        end

        // Retire the latched instruction on the edge of its final beat.
        if (last_done) begin
            valid_w_d    = 1'b1;
            pcsrc_w_d    = pcsrc_q;
            regwrite_w_d = regwrite_q;
            memtoreg_w_d = memtoreg_q;
            aluout_w_d   = alu_q;
            readdata_w_d = (state_q == RD_WAIT) ? rbuf_d : '0;
            wa3_w_d      = wa3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            alu_q        <= '0;
            rbuf_q       <= '0;
            pcsrc_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            wa3_q        <= '0;
            valid_w_q    <= 1'b0;
            pcsrc_w_q    <= 1'b0;
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
            aluout_w_q   <= '0;
            readdata_w_q <= '0;
            wa3_w_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            alu_q        <= alu_d;
            rbuf_q       <= rbuf_d;
            pcsrc_q      <= pcsrc_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            wa3_q        <= wa3_d;
            valid_w_q    <= valid_w_d;
            pcsrc_w_q    <= pcsrc_w_d;
            regwrite_w_q <= regwrite_w_d;
            memtoreg_w_q <= memtoreg_w_d;
            aluout_w_q   <= aluout_w_d;
            readdata_w_q <= readdata_w_d;
            wa3_w_q      <= wa3_w_d;
        end
    end

    assign ValidW    = valid_w_q;
    assign PCSrcW    = pcsrc_w_q;
    assign RegWriteW = regwrite_w_q;
    assign MemtoRegW = memtoreg_w_q;
    assign ALUOutW   = aluout_w_q;
    assign ReadDataW = readdata_w_q;
    assign WA3W      = wa3_w_q;
endmodule

// File: tb/tb_vec_mem_stage.sv
// Scoreboard bench for vec_mem_stage: expected W bundles and memory beats are queued at issue
// and compared when the DUT produces them; a small responder models the memory port.
module tb_vec_mem_stage;
    localparam int unsigned VEC_W  = 256;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NBEATS = 4;

    typedef struct packed {
        logic             pcsrc;
        logic             regwrite;
        logic             m2r;
        logic             m2r_care;
        logic [VEC_W-1:0] alu;
        logic [VEC_W-1:0] rd;
        logic [2:0]       wa3;
    } wexp_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BEAT_W-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             ValidM, PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
    logic [VEC_W-1:0] ALUResultM, WriteDataM;
    logic [2:0]       WA3M;
    logic             StallM, ValidW, PCSrcW, RegWriteW, MemtoRegW;
    logic [VEC_W-1:0] ALUOutW, ReadDataW;
    logic [2:0]       WA3W;

    wexp_t             w_q[$];
    beat_t             b_q[$];
    logic [BEAT_W-1:0] rd_beats[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                gnt_low_cnt = 0;
    logic              stray_rv = 1'b0;

    vec_mem_stage_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) mem_if ();

    vec_mem_stage #(.VEC_W(VEC_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ValidM     (ValidM),
        .PCSrcM     (PCSrcM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .WA3M       (WA3M),
        .StallM     (StallM),
        .mem        (mem_if),
        .ValidW     (ValidW),
        .PCSrcW     (PCSrcW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .WA3W       (WA3W)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VEC_W-1:0] got,
                         input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic pc, input logic rw, input logic mw,
                         input logic m2r, input logic [VEC_W-1:0] alu,
                         input logic [VEC_W-1:0] wd, input logic [2:0] wa3);
        ValidM     = v;
        PCSrcM     = pc;
        RegWriteM  = rw;
        MemWriteM  = mw;
        MemtoRegM  = m2r;
        ALUResultM = alu;
        WriteDataM = wd;
        WA3M       = wa3;
    endtask

    // Drive one M bundle, hold it while stalled, then check the stall length and W arrival.
    task automatic issue(input logic v, input logic pc, input logic rw, input logic mw,
                         input logic m2r, input logic [VEC_W-1:0] alu,
                         input logic [VEC_W-1:0] wd, input logic [2:0] wa3,
                         input logic [VEC_W-1:0] rd, input int exp_stall);
        wexp_t             e;
        beat_t             b;
        int                n;
        logic [ADDR_W-1:0] base;
        @(posedge clk);
        #1;
        drive(v, pc, rw, mw, m2r, alu, wd, wa3);
        base = alu[ADDR_W-1:0] & 32'hFFFF_FFF8;
        if (v) begin
            e.pcsrc    = pc;
            e.regwrite = rw;
            e.m2r      = m2r;
            e.m2r_care = !mw;
            e.alu      = alu;
            e.rd       = (m2r && !mw) ? rd : '0;
            e.wa3      = wa3;
            w_q.push_back(e);
        end
        if (v && (mw || m2r)) begin
            for (int i = 0; i < NBEATS; i++) begin
                b.we   = mw;
                b.addr = base + 32'(i * 8);
                b.data = wd[i*BEAT_W +: BEAT_W];
                b_q.push_back(b);
                if (!mw) rd_beats.push_back(rd[i*BEAT_W +: BEAT_W]);
            end
        end
        n = 0;
        @(negedge clk);
        while (StallM && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", n, exp_stall);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, '0, '0, 3'd0);
        @(negedge clk);
        if (v) begin
            check("valid_w_latency", ValidW, 1);
        end else begin
            check("bubble_valid_w", ValidW, 0);
            check("bubble_regwrite_w", RegWriteW, 0);
            check("bubble_pcsrc_w", PCSrcW, 0);
        end
    endtask

    initial begin : responder
        logic rd_acc;
        mem_if.gnt    = 1'b1;
        mem_if.rvalid = 1'b0;
        mem_if.rdata  = '0;
        forever begin
            @(negedge clk);
            rd_acc = mem_if.req && !mem_if.we && mem_if.gnt;
            @(posedge clk);
            #2;
            mem_if.rvalid = rd_acc || stray_rv;
            if (rd_acc) mem_if.rdata = (rd_beats.size() > 0) ? rd_beats.pop_front() : '0;
            else if (stray_rv) mem_if.rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            mem_if.gnt = (gnt_low_cnt == 0);
            if (gnt_low_cnt > 0) gnt_low_cnt--;
        end
    end

    initial begin : monitor
        wexp_t             e;
        beat_t             b;
        logic              hold_v;
        logic [ADDR_W-1:0] hold_addr;
        logic [BEAT_W-1:0] hold_wdata;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_v) begin
                check("hold_req", mem_if.req, 1);
                check("hold_addr", mem_if.addr, hold_addr);
                check("hold_wdata", mem_if.wdata, hold_wdata);
            end
            hold_v     = mem_if.req && !mem_if.gnt && !rst;
            hold_addr  = mem_if.addr;
            hold_wdata = mem_if.wdata;
            if (mem_if.req && mem_if.gnt) begin
                if (b_q.size() == 0) begin
                    check("beat_unexpected", b_q.size(), 1);
                end else begin
                    b = b_q.pop_front();
                    check("beat_we", mem_if.we, b.we);
                    check("beat_addr", mem_if.addr, b.addr);
                    if (b.we) check("beat_wdata", mem_if.wdata, b.data);
                end
            end
            if (ValidW) begin
                if (w_q.size() == 0) begin
                    check("w_unexpected", w_q.size(), 1);
                end else begin
                    e = w_q.pop_front();
                    check("w_pcsrc", PCSrcW, e.pcsrc);
                    check("w_regwrite", RegWriteW, e.regwrite);
                    if (e.m2r_care) check("w_memtoreg", MemtoRegW, e.m2r);
                    check("w_aluout", ALUOutW, e.alu);
                    check("w_readdata", ReadDataW, e.rd);
                    check("w_wa3", WA3W, e.wa3);
                end
            end
        end
    end

    initial begin : stimulus
        logic [VEC_W-1:0] wd;
        logic [VEC_W-1:0] rd;
        drive(0, 0, 0, 0, 0, '0, '0, 3'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_w", ValidW, 0);
        check("rst_mem_req", mem_if.req, 0);
        check("rst_stall", StallM, 0);
        check("rst_aluout", ALUOutW, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1, 0, 1, 0, 0, {32{8'hAB}}, '0, 3'd5, '0, 0);
        issue(0, 1, 1, 0, 0, {32{8'h5A}}, '0, 3'd4, '0, 0);

        @(posedge clk);
        #1;
        stray_rv = 1'b1;
        @(negedge clk);
        check("stray_stall", StallM, 0);
        check("stray_mem_req", mem_if.req, 0);
        @(posedge clk);
        #1;
        stray_rv = 1'b0;
        issue(1, 1, 1, 0, 0, {8{32'h1234_5678}}, '0, 3'd2, '0, 0);

        wd = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        issue(1, 0, 0, 1, 0, 256'h100, wd, 3'd1, '0, 4);

        rd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        issue(1, 0, 1, 0, 1, 256'h200, '0, 3'd6, rd, 8);

        rd = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
              64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        gnt_low_cnt = 4;
        issue(1, 1, 1, 0, 1, 256'h300, '0, 3'd3, rd, 11);

        wd = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
              64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        issue(1, 0, 0, 1, 1, 256'h10C, wd, 3'd7, '0, 4);

        issue(1, 0, 0, 1, 0, {224'hFACE, 32'hFFFF_FFF8}, ~wd, 3'd4, '0, 4);

        // Reset in the middle of a store: three beats granted, the fourth never issues.
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, {16{16'hC0DE}}, '0, 3'd6);
        @(posedge clk);
        #1;
        drive(1, 0, 1, 1, 0, 256'h400, wd, 3'd5);
        for (int i = 0; i < NBEATS; i++) begin
            b_q.push_back('{we: 1'b1, addr: 32'h400 + 32'(i * 8), data: wd[i*BEAT_W +: BEAT_W]});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_mem_req", mem_if.req, 0);
        check("midrst_stall_idle_rule", StallM, 1);
        check("midrst_valid_w", ValidW, 0);
        check("midrst_aluout", ALUOutW, 0);
        check("midrst_wa3", WA3W, 0);
        check("midrst_beats_left", b_q.size(), 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, '0, '0, 3'd0);
        @(negedge clk);
        check("midrst_stall_bubble", StallM, 0);
        check("midrst_mem_we", mem_if.we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_q.delete();

        issue(1, 0, 1, 0, 0, {8{32'h0BAD_F00D}}, '0, 3'd1, '0, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_w_empty", w_q.size(), 0);
        check("sb_beats_empty", b_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
